// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle RISC-V control FSM: sequences fetch/decode/execute/memory/writeback over one shared memory port.
// Latency: 3-5 cycles per instruction plus memory wait cycles; outputs are combinational from state and inputs.
// Backpressure: FETCH, MEM_RD and MEM_WR hold until mem_ready; after MEM_TIMEOUT idle waits the FSM traps on bus_err.
module multicycle_ctrl_fsm #(
    parameter int MEM_TIMEOUT = 15,
    parameter int RET_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             zero_flag,
    input  logic             mem_ready,
    output logic             pc_we,
    output logic             pc_src,
    output logic             ir_we,
    output logic             mem_req,
    output logic             mem_we,
    output logic             addr_sel,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             reg_we,
    output logic [1:0]       wb_sel,
    output logic             illegal,
    output logic             bus_err,
    output logic [RET_W-1:0] retire_cnt,
    output logic [3:0]       state_o
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_ALU_WB   = 4'd4,
        S_MEM_ADDR = 4'd5,
        S_MEM_RD   = 4'd6,
        S_LOAD_WB  = 4'd7,
        S_MEM_WR   = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd15
    } state_t;

    localparam int WCW = $clog2(MEM_TIMEOUT + 1);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    state_t           state, next_state;
    logic [WCW-1:0]   wait_cnt;
    logic             timeout;
    logic             is_mem_state;
    logic             retire, set_illegal, set_bus_err;

    // Raw (ungated) datapath controls; reset forces them to zero at the ports
    logic       pc_we_c, pc_src_c, ir_we_c, mem_req_c, mem_we_c, addr_sel_c, reg_we_c;
    logic [1:0] src_a_c, src_b_c, alu_op_c, wb_sel_c;

    assign is_mem_state = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
    // Counter has already seen MEM_TIMEOUT idle cycles and memory is still not ready
    assign timeout = is_mem_state && !mem_ready && (wait_cnt == WCW'(MEM_TIMEOUT));

    // Next-state and datapath control decode
    always_comb begin
        next_state  = state;
        pc_we_c     = 1'b0;
        pc_src_c    = 1'b0;
        ir_we_c     = 1'b0;
        mem_req_c   = 1'b0;
        mem_we_c    = 1'b0;
        addr_sel_c  = 1'b0;
        reg_we_c    = 1'b0;
        src_a_c     = 2'b00;
        src_b_c     = 2'b00;
        alu_op_c    = 2'b00;
        wb_sel_c    = 2'b00;
        retire      = 1'b0;
        set_illegal = 1'b0;
        set_bus_err = 1'b0;
        case (state)
            S_FETCH: begin
                mem_req_c = 1'b1;
                src_b_c   = 2'b01;
                if (mem_ready) begin
                    ir_we_c    = 1'b1;
                    pc_we_c    = 1'b1;
                    next_state = S_DECODE;
                end else if (timeout) begin
                    set_bus_err = 1'b1;
                    next_state  = S_TRAP;
                end
            end
            S_DECODE: begin
                // ALUOut captures OldPC + imm as the branch/JAL target
                src_a_c = 2'b01;
                src_b_c = 2'b10;
                if (opcode == OP_R)
                    next_state = S_EXEC_R;
                else if (opcode == OP_I)
                    next_state = S_EXEC_I;
                else if (opcode == OP_LOAD || opcode == OP_STORE)
                    next_state = S_MEM_ADDR;
                else if (opcode == OP_BR && (funct3 == 3'b000 || funct3 == 3'b001))
                    next_state = S_BRANCH;
                else if (opcode == OP_JAL)
                    next_state = S_JAL;
                else begin
                    set_illegal = 1'b1;
                    next_state  = S_TRAP;
                end
            end
            S_EXEC_R: begin
                src_a_c    = 2'b10;
                src_b_c    = 2'b00;
                alu_op_c   = 2'b10;
                next_state = S_ALU_WB;
            end
            S_EXEC_I: begin
                src_a_c    = 2'b10;
                src_b_c    = 2'b10;
                alu_op_c   = 2'b11;
                next_state = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_we_c   = 1'b1;
                wb_sel_c   = 2'b00;
                retire     = 1'b1;
                next_state = S_FETCH;
            end
            S_MEM_ADDR: begin
                src_a_c    = 2'b10;
                src_b_c    = 2'b10;
                next_state = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                mem_req_c  = 1'b1;
                addr_sel_c = 1'b1;
                if (mem_ready) begin
                    next_state = S_LOAD_WB;
                end else if (timeout) begin
                    set_bus_err = 1'b1;
                    next_state  = S_TRAP;
                end
            end
            S_LOAD_WB: begin
                reg_we_c   = 1'b1;
                wb_sel_c   = 2'b01;
                retire     = 1'b1;
                next_state = S_FETCH;
            end
            S_MEM_WR: begin
                mem_req_c  = 1'b1;
                mem_we_c   = 1'b1;
                addr_sel_c = 1'b1;
                if (mem_ready) begin
                    retire     = 1'b1;
                    next_state = S_FETCH;
                end else if (timeout) begin
                    set_bus_err = 1'b1;
                    next_state  = S_TRAP;
                end
            end
            S_BRANCH: begin
                src_a_c    = 2'b10;
                src_b_c    = 2'b00;
                alu_op_c   = 2'b01;
                pc_src_c   = 1'b1;
                pc_we_c    = (funct3 == 3'b000) ? zero_flag : ~zero_flag;
                retire     = 1'b1;
                next_state = S_FETCH;
            end
            S_JAL: begin
                reg_we_c   = 1'b1;
                wb_sel_c   = 2'b10;
                pc_we_c    = 1'b1;
                pc_src_c   = 1'b1;
                retire     = 1'b1;
                next_state = S_FETCH;
            end
            S_TRAP: begin
                next_state = S_TRAP;
            end
            default: begin
                next_state = S_TRAP;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= S_FETCH;
        else
            state <= next_state;
    end

    // Memory wait counter: restarts on every state change, counts idle cycles in memory states
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            wait_cnt <= '0;
        else if (next_state != state)
            wait_cnt <= '0;
        else if (is_mem_state && !mem_ready)
            wait_cnt <= wait_cnt + WCW'(1);
    end

    // Sticky trap flags and retired-instruction counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            illegal    <= 1'b0;
            bus_err    <= 1'b0;
            retire_cnt <= '0;
        end else begin
            illegal <= illegal | set_illegal;
            bus_err <= bus_err | set_bus_err;
            if (retire)
                retire_cnt <= retire_cnt + RET_W'(1);
        end
    end

    // Reset overrides every strobe and select immediately, so no write leaks after reset rises
    assign pc_we     = pc_we_c    & ~reset;
    assign pc_src    = pc_src_c   & ~reset;
    assign ir_we     = ir_we_c    & ~reset;
    assign mem_req   = mem_req_c  & ~reset;
    assign mem_we    = mem_we_c   & ~reset;
    assign addr_sel  = addr_sel_c & ~reset;
    assign reg_we    = reg_we_c   & ~reset;
    assign alu_src_a = reset ? 2'b00 : src_a_c;
    assign alu_src_b = reset ? 2'b00 : src_b_c;
    assign alu_op    = reset ? 2'b00 : alu_op_c;
    assign wb_sel    = reset ? 2'b00 : wb_sel_c;
    assign state_o   = state;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Bench for multicycle_ctrl_fsm: per-instruction expected cycle traces built from the instruction class.
// Latency: checks every cycle's state and controls, and retire_cnt after every instruction.
// Backpressure: random memory wait lengths, timeout boundary, reset abort of a pending store.
module tb_multicycle_ctrl_fsm;

    localparam int RET_W = 4;
    localparam int TMO   = 15;

    logic             clk = 1'b0;
    logic             reset;
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic             zero_flag;
    logic             mem_ready;
    logic             pc_we, pc_src, ir_we, mem_req, mem_we, addr_sel, reg_we;
    logic [1:0]       alu_src_a, alu_src_b, alu_op, wb_sel;
    logic             illegal, bus_err;
    logic [RET_W-1:0] retire_cnt;
    logic [3:0]       state_o;

    multicycle_ctrl_fsm #(.MEM_TIMEOUT(TMO), .RET_W(RET_W)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3),
        .zero_flag(zero_flag), .mem_ready(mem_ready),
        .pc_we(pc_we), .pc_src(pc_src), .ir_we(ir_we), .mem_req(mem_req),
        .mem_we(mem_we), .addr_sel(addr_sel), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_we(reg_we),
        .wb_sel(wb_sel), .illegal(illegal), .bus_err(bus_err),
        .retire_cnt(retire_cnt), .state_o(state_o)
    );

    always #5 clk = ~clk;

    // Packed control vector: {pc_we,pc_src,ir_we,mem_req,mem_we,addr_sel,a,b,op,reg_we,wb}
    logic [14:0] dut_outs;
    assign dut_outs = {pc_we, pc_src, ir_we, mem_req, mem_we, addr_sel,
                       alu_src_a, alu_src_b, alu_op, reg_we, wb_sel};

    typedef struct {
        logic [3:0]  st;
        logic        rdy;
        logic        zf;
        logic [14:0] outs;
    } cyc_t;

    cyc_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   ret_model = 0;

    function automatic logic [14:0] O(input logic pw, ps, iw, mr, mw, asl,
                                      input logic [1:0] a, b, op,
                                      input logic rw, input logic [1:0] wb);
        return {pw, ps, iw, mr, mw, asl, a, b, op, rw, wb};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [3:0] st, input logic rdy, input logic [14:0] outs);
        cyc_t c;
        c.st   = st;
        c.rdy  = rdy;
        c.zf   = 1'($urandom);
        c.outs = outs;
        q.push_back(c);
    endtask

    // Fetch with 'lat' not-ready cycles then the accepting cycle, followed by decode
    task automatic push_fetch_decode(input int lat);
        for (int i = 0; i < lat; i++) push(4'd0, 1'b0, O(0,0,0,1,0,0,2'd0,2'd1,2'd0,0,2'd0));
        push(4'd0, 1'b1, O(1,0,1,1,0,0,2'd0,2'd1,2'd0,0,2'd0));
        push(4'd1, 1'($urandom), O(0,0,0,0,0,0,2'd1,2'd2,2'd0,0,2'd0));
    endtask

    // kind: 0 R, 1 I, 2 load, 3 store, 4 BEQ, 5 BNE, 6 JAL
    task automatic build_instr(input int kind, input logic zf, input int flat, input int mlat);
        cyc_t c;
        case (kind)
            0: begin opcode = 7'b0110011; funct3 = 3'($urandom); end
            1: begin opcode = 7'b0010011; funct3 = 3'($urandom); end
            2: begin opcode = 7'b0000011; funct3 = 3'($urandom); end
            3: begin opcode = 7'b0100011; funct3 = 3'($urandom); end
            4: begin opcode = 7'b1100011; funct3 = 3'b000; end
            5: begin opcode = 7'b1100011; funct3 = 3'b001; end
            default: begin opcode = 7'b1101111; funct3 = 3'($urandom); end
        endcase
        push_fetch_decode(flat);
        case (kind)
            0, 1: begin
                if (kind == 0) push(4'd2, 1'($urandom), O(0,0,0,0,0,0,2'd2,2'd0,2'd2,0,2'd0));
                else           push(4'd3, 1'($urandom), O(0,0,0,0,0,0,2'd2,2'd2,2'd3,0,2'd0));
                push(4'd4, 1'($urandom), O(0,0,0,0,0,0,2'd0,2'd0,2'd0,1,2'd0));
            end
            2: begin
                push(4'd5, 1'($urandom), O(0,0,0,0,0,0,2'd2,2'd2,2'd0,0,2'd0));
                for (int i = 0; i < mlat; i++) push(4'd6, 1'b0, O(0,0,0,1,0,1,2'd0,2'd0,2'd0,0,2'd0));
                push(4'd6, 1'b1, O(0,0,0,1,0,1,2'd0,2'd0,2'd0,0,2'd0));
                push(4'd7, 1'($urandom), O(0,0,0,0,0,0,2'd0,2'd0,2'd0,1,2'd1));
            end
            3: begin
                push(4'd5, 1'($urandom), O(0,0,0,0,0,0,2'd2,2'd2,2'd0,0,2'd0));
                for (int i = 0; i < mlat; i++) push(4'd8, 1'b0, O(0,0,0,1,1,1,2'd0,2'd0,2'd0,0,2'd0));
                push(4'd8, 1'b1, O(0,0,0,1,1,1,2'd0,2'd0,2'd0,0,2'd0));
            end
            4, 5: begin
                push(4'd9, 1'($urandom), O((kind == 4) ? zf : ~zf,1,0,0,0,0,2'd2,2'd0,2'd1,0,2'd0));
                c = q.pop_back();
                c.zf = zf;
                q.push_back(c);
            end
            default: push(4'd10, 1'($urandom), O(1,1,0,0,0,0,2'd0,2'd0,2'd0,1,2'd2));
        endcase
        ret_model++;
    endtask

    // Entered at a falling edge; drives each cycle's inputs, checks, and ends at a falling edge
    task automatic run_queue(input string tag);
        cyc_t c;
        while (q.size() > 0) begin
            c = q.pop_front();
            mem_ready = c.rdy;
            zero_flag = c.zf;
            #1;
            chk({tag, "_state"}, 32'(state_o), 32'(c.st));
            chk({tag, "_ctrl"},  32'(dut_outs), 32'(c.outs));
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        ret_model = 0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; opcode = '0; funct3 = '0; zero_flag = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        // Reset state: everything zero even though FETCH would request memory
        chk("rst_state",   32'(state_o),    32'd0);
        chk("rst_ctrl",    32'(dut_outs),   32'd0);
        chk("rst_retire",  32'(retire_cnt), 32'd0);
        chk("rst_illegal", 32'(illegal),    32'd0);
        chk("rst_buserr",  32'(bus_err),    32'd0);
        reset = 1'b0;

        // Directed: R-type with ready tied, load with 3 waits, BEQ/BNE with zero=1, JAL
        build_instr(0, 1'b0, 0, 0); run_queue("rtype");
        chk("rtype_retire", 32'(retire_cnt), 32'(ret_model % (1 << RET_W)));
        build_instr(2, 1'b0, 0, 3); run_queue("load3");
        chk("load_retire", 32'(retire_cnt), 32'(ret_model % (1 << RET_W)));
        build_instr(4, 1'b1, 0, 0); run_queue("beq_taken");
        build_instr(5, 1'b1, 0, 0); run_queue("bne_not");
        chk("br_retire", 32'(retire_cnt), 32'(ret_model % (1 << RET_W)));
        build_instr(6, 1'b0, 0, 0); run_queue("jal");
        build_instr(3, 1'b0, 2, 4); run_queue("store");

        // Random instruction mix; retire count wraps several times
        for (int n = 0; n < 60; n++) begin
            build_instr(int'($urandom_range(0, 6)), 1'($urandom),
                        int'($urandom_range(0, 4)), int'($urandom_range(0, 6)));
            run_queue("rand");
            chk("rand_retire", 32'(retire_cnt), 32'(ret_model % (1 << RET_W)));
        end

        // Illegal opcode: FETCH, DECODE, then TRAP in the third cycle with no strobes
        opcode = 7'b0000000; funct3 = 3'b000;
        push_fetch_decode(0);
        for (int i = 0; i < 3; i++) push(4'd15, 1'($urandom), 15'd0);
        run_queue("illop");
        chk("illop_flag",   32'(illegal),    32'd1);
        chk("illop_buserr", 32'(bus_err),    32'd0);
        chk("illop_retire", 32'(retire_cnt), 32'(ret_model % (1 << RET_W)));
        // Reset clears state and illegal without waiting for a clock edge
        #2 reset = 1'b1;
        #1;
        chk("async_rst_state",   32'(state_o), 32'd0);
        chk("async_rst_illegal", 32'(illegal), 32'd0);
        chk("async_rst_retire",  32'(retire_cnt), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        ret_model = 0;

        // Branch opcode with unsupported funct3 is illegal
        opcode = 7'b1100011; funct3 = 3'b010;
        push_fetch_decode(1);
        push(4'd15, 1'b1, 15'd0);
        run_queue("illbr");
        chk("illbr_flag", 32'(illegal), 32'd1);
        do_reset();

        // Timeout: fifteen idle waits, then a sixteenth not-ready cycle traps
        for (int i = 0; i <= TMO; i++) push(4'd0, 1'b0, O(0,0,0,1,0,0,2'd0,2'd1,2'd0,0,2'd0));
        push(4'd15, 1'b1, 15'd0);
        run_queue("tmo");
        chk("tmo_buserr",  32'(bus_err), 32'd1);
        chk("tmo_illegal", 32'(illegal), 32'd0);
        do_reset();

        // Boundary: memory answers on that sixteenth cycle, which wins over the timeout
        opcode = 7'b0110011;
        push_fetch_decode(TMO);
        push(4'd2, 1'b0, O(0,0,0,0,0,0,2'd2,2'd0,2'd2,0,2'd0));
        run_queue("tmo_edge");
        chk("tmo_edge_buserr", 32'(bus_err), 32'd0);
        do_reset();

        // Timeout inside MEM_RD also traps
        opcode = 7'b0000011;
        push_fetch_decode(0);
        push(4'd5, 1'b0, O(0,0,0,0,0,0,2'd2,2'd2,2'd0,0,2'd0));
        for (int i = 0; i <= TMO; i++) push(4'd6, 1'b0, O(0,0,0,1,0,1,2'd0,2'd0,2'd0,0,2'd0));
        push(4'd15, 1'b0, 15'd0);
        run_queue("rd_tmo");
        chk("rd_tmo_buserr", 32'(bus_err), 32'd1);
        do_reset();

        // Reset while a store is pending kills mem_we at once
        opcode = 7'b0100011;
        push_fetch_decode(0);
        push(4'd5, 1'b0, O(0,0,0,0,0,0,2'd2,2'd2,2'd0,0,2'd0));
        push(4'd8, 1'b0, O(0,0,0,1,1,1,2'd0,2'd0,2'd0,0,2'd0));
        run_queue("wr_abort");
        mem_ready = 1'b0;
        #1;
        chk("wr_pending_we", 32'(mem_we), 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("wr_abort_we",    32'(mem_we),  32'd0);
        chk("wr_abort_req",   32'(mem_req), 32'd0);
        chk("wr_abort_state", 32'(state_o), 32'd0);
        @(negedge clk);
        mem_ready = 1'b1;
        @(negedge clk);
        chk("wr_abort_retire", 32'(retire_cnt), 32'd0);
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
